// File: rtl/fir_sequencer.sv
// Time-multiplexed controller for a symmetric FIR: buffers samples in a ring and
// runs one pre-adder/multiplier/accumulator over the coefficient pairs per sample.
module fir_sequencer #(
  parameter int NTAPS = 31,
  parameter int DW    = 10,
  parameter int CW    = 16,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_valid,
  input  logic [DW-1:0] voltage,
  input  logic          coef_we,
  input  logic [3:0]    coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic [DW-1:0] filtered,
  output logic          filtered_valid,
  output logic          busy,
  output logic          overrun,
  output logic          coef_rejected,
  output logic [1:0]    state_dbg
);

  localparam int NCOEF = (NTAPS + 1) / 2;
  localparam int PW    = $clog2(NTAPS);
  localparam int KW    = $clog2(NCOEF);

  localparam logic [PW-1:0]        PTR_LAST = PW'(NTAPS - 1);
  localparam logic [PW+1:0]        NT_W     = (PW+2)'(NTAPS);
  localparam logic [KW-1:0]        K_LAST   = KW'(NCOEF - 1);
  localparam logic signed [AW-1:0] R_MAX    = AW'((1 << DW) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [DW-1:0]        ring [NTAPS];
  logic signed [CW-1:0] coef_mem [NCOEF];
  logic [PW-1:0]        wr_ptr;
  logic [KW-1:0]        k;
  logic signed [AW-1:0] acc;

  // sample_valid has no ready: a strobe is taken only in IDLE; anything seen
  // while busy is dropped and flagged through the sticky overrun bit.
  logic sample_accept;
  logic sample_drop;
  logic coef_ok;

  assign sample_accept = (state == IDLE) && sample_valid;
  assign sample_drop   = (state != IDLE) && sample_valid;
  assign coef_ok       = coef_we && (state == IDLE) && !sample_valid;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Next write slot, wrapping at the end of the ring
  logic [PW-1:0] ptr_inc;
  assign ptr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);

  // Tap pair addresses: newest-minus-k and oldest-plus-k, both modulo NTAPS
  logic [PW+1:0] a_sum;
  logic [PW+1:0] b_sum;
  logic [PW-1:0] idx_a;
  logic [PW-1:0] idx_b;

  always_comb begin
    a_sum = {2'b00, wr_ptr} + NT_W - {{(PW+2-KW){1'b0}}, k};
    b_sum = {2'b00, wr_ptr} + {{(PW+2-KW){1'b0}}, k} + (PW+2)'(1);
    idx_a = (a_sum >= NT_W) ? PW'(a_sum - NT_W) : PW'(a_sum);
    idx_b = (b_sum >= NT_W) ? PW'(b_sum - NT_W) : PW'(b_sum);
  end

  logic [DW-1:0]        tap_a;
  logic [DW-1:0]        tap_b;
  logic [DW:0]          pre;
  logic signed [CW-1:0] coef_k;
  logic signed [AW-1:0] pre_s;
  logic signed [AW-1:0] coef_s;
  logic signed [AW-1:0] prod;

  always_comb begin
    tap_a  = ring[idx_a];
    tap_b  = ring[idx_b];
    pre    = (k == K_LAST) ? {1'b0, tap_a} : ({1'b0, tap_a} + {1'b0, tap_b});
    coef_k = coef_mem[k];
    pre_s  = $signed({{(AW-DW-1){1'b0}}, pre});
    coef_s = {{(AW-CW){coef_k[CW-1]}}, coef_k};
    prod   = pre_s * coef_s;
  end

  // Q1.15 rescale followed by clamp to the unsigned output range
  logic signed [AW-1:0] r;
  logic [DW-1:0]        sat;

  always_comb begin
    r = acc >>> (CW - 1);
    if (r[AW-1]) begin
      sat = '0;
    end else if (r > R_MAX) begin
      sat = '1;
    end else begin
      sat = r[DW-1:0];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (sample_valid) state_next = MAC;
      MAC:  if (k == K_LAST) state_next = OUT;
      OUT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wr_ptr         <= PTR_LAST;
      k              <= '0;
      acc            <= '0;
      filtered       <= '0;
      filtered_valid <= 1'b0;
      overrun        <= 1'b0;
      coef_rejected  <= 1'b0;
      for (int i = 0; i < NTAPS; i++) ring[i] <= '0;
      for (int i = 0; i < NCOEF; i++) coef_mem[i] <= '0;
    end else begin
      state          <= state_next;
      filtered_valid <= 1'b0;
      coef_rejected  <= coef_we && !coef_ok;
      if (sample_drop) overrun <= 1'b1;
      if (coef_ok) coef_mem[coef_addr] <= coef_data;
      case (state)
        IDLE: begin
          if (sample_accept) begin
            ring[ptr_inc] <= voltage;
            wr_ptr        <= ptr_inc;
            acc           <= '0;
            k             <= '0;
          end
        end
        MAC: begin
          acc <= acc + prod;
          k   <= k + KW'(1);
        end
        OUT: begin
          filtered       <= sat;
          filtered_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

Time-multiplexed controller for the 31-tap symmetric FIR low-pass stage that sits between the SPI sample receiver and the downstream signal-processing logic. It buffers incoming 10-bit voltage samples, holds the 16 programmable symmetric coefficients, and runs one shared pre-adder/multiplier/accumulator through the 16 coefficient pairs per sample. It produces one saturated 10-bit filtered sample per accepted input.

## Interface
Parameters:
- NTAPS, 31, filter length; fixed odd, symmetric; NCOEF = (NTAPS+1)/2 = 16
- DW, 10, sample and output width (unsigned)
- CW, 16, coefficient width (signed, Q1.15)
- AW, 32, accumulator width (signed)

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- sample_valid  in  1  one-cycle strobe; voltage holds a new sample
- voltage  in  DW  new input sample, unsigned
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  coefficient index k, 0..15 (k=15 is the center tap)
- coef_data  in  CW  signed coefficient value
- filtered  out  DW  latest filtered sample, unsigned; held between results
- filtered_valid  out  1  one-cycle pulse when filtered updates
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky; set when a sample is dropped
- coef_rejected  out  1  one-cycle pulse when a coefficient write is ignored

## Operation
- Storage:
  - 31-entry sample ring, DW bits per entry; wr_ptr runs 0..30 and wraps 30 -> 0.
  - 16-entry coefficient register file.
  - Signed AW accumulator.
- FSM states are IDLE, MAC and OUT.
  - IDLE: when sample_valid=1, write voltage to ring[wr_ptr+1 mod 31], advance wr_ptr to that slot, clear acc, set k=0, go to MAC.
  - MAC: one tap pair per cycle, k=0..15.
    - For k<15: pre = ring[(wr_ptr-k) mod 31] + ring[(wr_ptr+1+k) mod 31], 11-bit unsigned. The second term is x[n-30+k].
    - For k=15: pre = ring[(wr_ptr-15) mod 31], the center tap alone.
    - acc += signed(pre) * coef[k]. The product is 27-bit signed, sign-extended to AW.
    - At k=15 go to OUT.
  - OUT: compute r = acc >>> 15 (arithmetic shift), then clamp. r<0 gives filtered=0, r>1023 gives 1023, otherwise r[9:0]. Assert filtered_valid and go to IDLE.
- Worst-case |acc| is 31*1023*32768 < 2^31, so no accumulator overflow is possible.
- Sample_valid arrives while busy=1 (MAC or OUT):
  - The sample is dropped.
  - The ring and wr_ptr are unchanged.
  - overrun is set and stays set until reset.
- Coefficient writes:
  - coef_we in IDLE with no sample_valid in the same cycle: coef[coef_addr] <= coef_data, visible to the next computation.
  - coef_we when busy=1, or in the same cycle as an accepted sample_valid: the write is ignored and coef_rejected pulses. Coefficients stay constant during a computation.
- Reset:
  - FSM goes to IDLE; wr_ptr=30, so the first sample lands in slot 0.
  - All ring entries and coefficients are set to 0, acc=0.
  - Outputs: filtered=0, filtered_valid=0, busy=0, overrun=0, coef_rejected=0.
  - Reset mid-computation aborts it with no filtered_valid pulse. Reset wins over a simultaneous sample_valid or coef_we.

## Timing
- Edge E0: sample accepted and written into the ring.
- Edges E1..E16: the 16 MAC steps.
- Edge E17: filtered and filtered_valid registered. filtered_valid is high for exactly the cycle after E17.
- Latency: 17 clocks from the accepting edge to filtered_valid.
- busy is high after E0 through the cycle ending at E17. A sample_valid sampled at E1..E17 is dropped.
- Earliest next accepted sample is at E18, giving a maximum throughput of 1 sample per 18 clocks.
- filtered holds its value between pulses. coef_rejected is registered: it is high during the cycle after the rejected write.

## Test plan
- Reset state:
  - Assert reset, then check all outputs are 0.
  - Write coef[15]=16384 and send sample 1000, then 15 samples of 0.
  - Required: 16 filtered_valid pulses with outputs 0 ×15 then 500, with each pulse 17 clocks after its sample.
- Symmetric taps and ring wrap:
  - Set coef[0]=32767, others 0. Send impulse 1000, then 40 zeros at 1 sample per 18 clocks.
  - Required: outputs 999 at sample indices 0 and 30, 0 elsewhere. This exercises wr_ptr wrap 30 -> 0.
- Saturation:
  - Set all coefs to 32767 and stream 1023.
  - Required: output clamps to 1023 once the ring is full.
  - Then set coef[0]=-32768 with the others 0, and apply input 1000 after reset. Required: output 0, negative clamp.
- Overrun:
  - Send samples at E0 and at E9.
  - Required: second sample dropped, overrun=1 and stays 1, exactly one filtered_valid pulse.
  - A sample at E18 is accepted normally.
- Coefficient rejection:
  - coef_we during MAC: required coef_rejected pulse and unchanged results.
  - coef_we in the same cycle as sample_valid in IDLE: sample accepted, write rejected.
- Reset mid-operation:
  - Assert reset at E8.
  - Required: no filtered_valid pulse, busy=0, ring cleared. The next sample computes as if it were the first after power-up.
